alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle successor to the combinational datapath ALU, driven by the same MIPS R-type funct codes on Signal. Adds a registered result with valid/ready handshakes, signed-overflow and illegal-op flags, and an iterative unsigned multiplier writing internal HI/LO registers (read back with MFHI/MFLO). Sits in the execute stage and stalls the front end through in_ready while a multiply is in flight.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets)
in_valid  input  1  operation request
in_ready  output  1  block can accept; high only in IDLE
dataA  input  WIDTH  operand A, sampled on accept
dataB  input  WIDTH  operand B, sampled on accept
Signal  input  6  funct code, sampled on accept
out_valid  output  1  dataOut/flags valid
out_ready  input  1  consumer accepts result
dataOut  output  WIDTH  registered result
overflow  output  1  signed overflow of ADD/SUB; 0 for other ops
illegal  output  1  Signal not a supported code

Behaviour:
- Codes: AND=36 (100100), OR=37 (100101), ADD=32 (100000), SUB=34 (100010), SLT=42 (101010), MULTU=25 (011001), MFHI=16 (010000), MFLO=18 (010010). All others are illegal.
- Reset (reset==0 at edge): state->IDLE, dataOut=0, out_valid=0, overflow=0, illegal=0, HI=0, LO=0, counter=0. Overrides everything, including a multiply in progress (aborted, no HI/LO update). in_ready=1 from the first cycle after reset deasserts.
- Accept = in_valid && in_ready at a clk edge; dataA, dataB and Signal are latched. in_valid while in_ready=0 is ignored; no queueing.
- FSM states IDLE, MUL, DONE; in_ready = (state==IDLE).
  IDLE --accept, non-MULTU--> DONE; the result is registered on the same edge (latency 1).
  IDLE --accept, MULTU--> MUL; product accumulator cleared, counter=0.
  MUL: one shift-add step per cycle (add multiplicand if current multiplier LSB set, shift). After WIDTH steps: {HI,LO}=2*WIDTH-bit unsigned product, dataOut=LO, -> DONE. out_valid rises WIDTH+1 edges after the accept edge.
  DONE: out_valid=1; dataOut and flags held stable until out_ready==1 at an edge -> IDLE, out_valid=0 on that edge. The next accept is possible one cycle later (max throughput 1 op per 2 cycles for single-cycle ops).
- Arithmetic is mod 2^WIDTH. ADD: overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]). SUB: overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]). SLT: signed compare, result 1 or 0 zero-extended, correct even when A-B overflows; overflow=0.
- MFHI/MFLO: dataOut=HI/LO, latency 1; operands ignored. HI/LO change only on MULTU completion or reset.
- Illegal code: dataOut=0, illegal=1, overflow=0, latency 1, HI/LO untouched.
- out_ready is ignored outside DONE. A held-high out_ready gives a one-cycle out_valid pulse.

Test Plan:
- Reset low 2 cycles then high; ADD 7+5 accepted with out_ready=1 -> out_valid=1 on the next edge, dataOut=12, overflow=0; in_ready low for exactly one cycle.
- SUB 0x7FFFFFFF-0xFFFFFFFF -> dataOut=0x80000000, overflow=1. ADD 0x80000000+0x80000000 -> 0, overflow=1. SLT 0xFFFFFFFF vs 1 -> 1. SLT 0x7FFFFFFF vs 0x80000000 -> 0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> out_valid exactly 33 edges after accept, dataOut=0x00000001. Then MFHI -> 0xFFFFFFFE and MFLO -> 0x00000001. in_valid pulses during MUL are ignored.
- Backpressure: OR 0xF0F0F0F0|0x0F0F0F0F with out_ready=0 for 3 cycles -> out_valid and dataOut=0xFFFFFFFF stable, in_ready=0 throughout; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Reset pulled low in MUL cycle 10 of MULTU 3x5 -> IDLE next edge, out_valid=0; a following MFHI/MFLO returns 0/0.
- Signal=6'b000000, A=5, B=3 -> illegal=1, dataOut=0. A following AND 0xC & 0xA -> 8 with illegal=0. Repeat the ADD overflow case at WIDTH=8: 0x7F+0x01 -> 0x80, overflow=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   master: drives in_valid, dataA, dataB, Signal, out_ready
//   slave : drives in_ready, out_valid, dataOut, overflow, illegal
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, dataA, dataB, Signal, out_ready,
        input  in_ready, out_valid, dataOut, overflow, illegal
    );

    modport slave (
        input  in_valid, dataA, dataB, Signal, out_ready,
        output in_ready, out_valid, dataOut, overflow, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU driven by MIPS R-type funct codes.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : alu_mc_if slave (request handshake, operands, funct code,
//           registered result with overflow/illegal flags)
// Single-cycle ops complete on the accept edge. MULTU runs a shift-add
// multiplier over WIDTH cycles plus one completion cycle, writing HI/LO.
//
// state | meaning
// IDLE  | ready to accept a request (in_ready=1)
// MUL   | iterating shift-add multiply, one step per cycle
// DONE  | result held on dataOut until out_ready
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic   clk,
    input logic   reset,
    alu_mc_if.slave bus
);
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dout;
    logic               ovf, ill, vld;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_ill;
    logic [WIDTH-1:0]   sum_ab, dif_ab;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = vld;
    assign bus.dataOut   = dout;
    assign bus.overflow  = ovf;
    assign bus.illegal   = ill;

    assign sum_ab = bus.dataA + bus.dataB;
    assign dif_ab = bus.dataA - bus.dataB;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.Signal)
            F_AND: alu_res = bus.dataA & bus.dataB;
            F_OR:  alu_res = bus.dataA | bus.dataB;
            F_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (bus.dataA[WIDTH-1] == bus.dataB[WIDTH-1]) &&
                          (sum_ab[WIDTH-1] != bus.dataA[WIDTH-1]);
            end
            F_SUB: begin
                alu_res = dif_ab;
                alu_ovf = (bus.dataA[WIDTH-1] != bus.dataB[WIDTH-1]) &&
                          (dif_ab[WIDTH-1] != bus.dataA[WIDTH-1]);
            end
            // Direct signed compare: immune to A-B wraparound.
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            default: alu_ill = 1'b1;
        endcase
    end

    // Upper half accumulates, lower half holds the remaining multiplier
    // bits; the carry of the add is shifted into the top bit.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {step_sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
            ill   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.Signal == F_MULTU) begin
                            mcand <= bus.dataA;
                            prod  <= {{WIDTH{1'b0}}, bus.dataB};
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            dout  <= alu_res;
                            ovf   <= alu_ovf;
                            ill   <= alu_ill;
                            vld   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        lo    <= prod[WIDTH-1:0];
                        dout  <= prod[WIDTH-1:0];
                        ovf   <= 1'b0;
                        ill   <= 1'b0;
                        vld   <= 1'b1;
                        state <= DONE;
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nchecks = 0;
    int   nerrors = 0;

    alu_mc_if #(.WIDTH(32)) bus32 ();
    alu_mc_if #(.WIDTH(8))  bus8 ();

    alu_mc #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus32));
    alu_mc #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 32-bit instance ----------------
    logic [31:0] m_hi, m_lo;
    bit          known = 0;
    bit          busy, ov_exp_v, after_rst;
    int          wait_cnt;
    logic [31:0] e_data;
    logic        e_ovf, e_ill, e_mul;
    logic [63:0] e_prod;

    function automatic void model_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ov, output logic il,
                                     output logic mul, output logic [63:0] p);
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s = 0; r = '0; ov = 0; il = 0; mul = 0; p = '0;
        case (c)
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_ADD: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            F_SUB: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            F_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            F_MULTU: begin p = {32'd0, a} * {32'd0, b}; mul = 1; r = p[31:0]; end
            F_MFHI: r = m_hi;
            F_MFLO: r = m_lo;
            default: il = 1;
        endcase
    endfunction

    // Check outputs produced by the last edge, then predict the next edge.
    always @(negedge clk) begin
        if (known) begin
            chk("in_ready", 64'(bus32.in_ready), 64'(!busy));
            chk("out_valid", 64'(bus32.out_valid), 64'(ov_exp_v));
            if (ov_exp_v) begin
                chk("dataOut", 64'(bus32.dataOut), 64'(e_data));
                chk("overflow", 64'(bus32.overflow), 64'(e_ovf));
                chk("illegal", 64'(bus32.illegal), 64'(e_ill));
            end
            if (after_rst) begin
                chk("rst_dataOut", 64'(bus32.dataOut), 64'd0);
                chk("rst_flags", 64'({bus32.overflow, bus32.illegal}), 64'd0);
            end
        end
        after_rst = 0;
        if (!reset) begin
            known = 1; after_rst = 1;
            busy = 0; ov_exp_v = 0; wait_cnt = 0;
            m_hi = '0; m_lo = '0;
        end else if (busy) begin
            if (ov_exp_v) begin
                if (bus32.out_ready) begin busy = 0; ov_exp_v = 0; end
            end else begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    ov_exp_v = 1;
                    m_hi = e_prod[63:32];
                    m_lo = e_prod[31:0];
                end
            end
        end else if (bus32.in_valid) begin
            model_op(bus32.Signal, bus32.dataA, bus32.dataB, e_data, e_ovf, e_ill, e_mul, e_prod);
            busy = 1;
            if (e_mul) begin wait_cnt = 33; ov_exp_v = 0; end
            else ov_exp_v = 1;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic issue(input string nm, input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_ov, input logic exp_il,
                         input int exp_lat, input int hold, input bit noise);
        int n;
        n = 0;
        while (!bus32.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_ready_wait"}, 64'(bus32.in_ready), 64'd1);
        bus32.in_valid = 1; bus32.dataA = a; bus32.dataB = b; bus32.Signal = code;
        bus32.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus32.in_valid = 0; bus32.dataA = '0; bus32.dataB = '0; bus32.Signal = F_AND;
        n = 0;
        while (!bus32.out_valid && n < 100) begin
            if (noise) begin
                bus32.in_valid = n[1];
                bus32.Signal = F_ADD;
                bus32.dataA = 32'(n);
            end
            @(posedge clk); #1;
            n++;
        end
        bus32.in_valid = 0;
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
        chk({nm, "_data"}, 64'(bus32.dataOut), 64'(exp_d));
        chk({nm, "_ovf"}, 64'(bus32.overflow), 64'(exp_ov));
        chk({nm, "_ill"}, 64'(bus32.illegal), 64'(exp_il));
        if (hold == 0) begin
            @(posedge clk); #1;
            bus32.out_ready = 0;
        end else begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk({nm, "_hold_valid"}, 64'(bus32.out_valid), 64'd1);
                chk({nm, "_hold_data"}, 64'(bus32.dataOut), 64'(exp_d));
                chk({nm, "_hold_inready"}, 64'(bus32.in_ready), 64'd0);
            end
            bus32.out_ready = 1;
            @(posedge clk); #1;
            bus32.out_ready = 0;
            chk({nm, "_release_valid"}, 64'(bus32.out_valid), 64'd0);
            chk({nm, "_release_inready"}, 64'(bus32.in_ready), 64'd1);
        end
    endtask

    task automatic issue8(input string nm, input logic [5:0] code, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_ov, input int exp_lat);
        int n;
        bus8.in_valid = 1; bus8.dataA = a; bus8.dataB = b; bus8.Signal = code; bus8.out_ready = 1;
        @(posedge clk); #1;
        bus8.in_valid = 0;
        n = 0;
        while (!bus8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
        chk({nm, "_data"}, 64'(bus8.dataOut), 64'(exp_d));
        chk({nm, "_ovf"}, 64'(bus8.overflow), 64'(exp_ov));
        @(posedge clk); #1;
        bus8.out_ready = 0;
        chk({nm, "_done"}, 64'(bus8.out_valid), 64'd0);
    endtask

    initial begin
        bus32.in_valid = 0; bus32.dataA = '0; bus32.dataB = '0; bus32.Signal = '0; bus32.out_ready = 0;
        bus8.in_valid = 0; bus8.dataA = '0; bus8.dataB = '0; bus8.Signal = '0; bus8.out_ready = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        issue("add_7_5",   F_ADD, 32'd7, 32'd5, 32'd12, 0, 0, 0, 0, 0);
        issue("sub_ovf",   F_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0, 0, 0);
        issue("add_ovf",   F_ADD, 32'h80000000, 32'h80000000, 32'h0, 1, 0, 0, 0, 0);
        issue("sub_neg",   F_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
        issue("slt_neg",   F_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 0, 0);
        issue("slt_wrap",  F_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 0, 0, 0, 0, 0);
        issue("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33, 0, 1);
        issue("mfhi",      F_MFHI, 32'd9, 32'd9, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
        issue("mflo",      F_MFLO, 32'd9, 32'd9, 32'h00000001, 0, 0, 0, 0, 0);
        issue("or_hold",   F_OR, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0, 3, 0);

        // Abort a multiply with reset partway through.
        bus32.in_valid = 1; bus32.dataA = 32'd3; bus32.dataB = 32'd5; bus32.Signal = F_MULTU;
        @(posedge clk); #1;
        bus32.in_valid = 0;
        repeat (9) begin @(posedge clk); #1; end
        chk("mul_busy", 64'(bus32.in_ready), 64'd0);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        chk("abort_valid", 64'(bus32.out_valid), 64'd0);
        chk("abort_inready", 64'(bus32.in_ready), 64'd1);
        issue("mfhi_rst",  F_MFHI, 32'd1, 32'd1, 32'd0, 0, 0, 0, 0, 0);
        issue("mflo_rst",  F_MFLO, 32'd1, 32'd1, 32'd0, 0, 0, 0, 0, 0);

        issue("illegal",   6'd0, 32'd5, 32'd3, 32'd0, 0, 1, 0, 0, 0);
        issue("and_c_a",   F_AND, 32'hC, 32'hA, 32'h8, 0, 0, 0, 0, 0);
        issue("multu_3_5", F_MULTU, 32'd3, 32'd5, 32'd15, 0, 0, 33, 1, 0);
        issue("mfhi_15",   F_MFHI, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0);

        issue8("w8_add_ovf", F_ADD, 8'h7F, 8'h01, 8'h80, 1, 0);
        issue8("w8_multu",   F_MULTU, 8'hFF, 8'hFF, 8'h01, 0, 9);
        issue8("w8_mfhi",    F_MFHI, 8'h00, 8'h00, 8'hFE, 0, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", nchecks, nerrors);
        $fatal(1, "timeout");
    end
endmodule
